pcs_10g_dec_64b66b: RTL and testbench

//   Receive-side 64B/66B decoder (IEEE 802.3 Cl.49). Takes descrambled 66-bit

---
 rtl/pcs_10g_dec_64b66b.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pcs_10g_dec_64b66b.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_10g_dec_64b66b.sv
// ---------------------------------------------------------------------------
// pcs_10g_dec_64b66b
//
// Receive-side 64B/66B decoder for a 10GBASE-R PCS. Each descrambled 66-bit
// block is classified as Control, Start, Data, Terminate or Error. A receive
// sequence FSM then checks that the blocks arrive in a legal order. The block
// is turned into one registered XGMII word (8 lanes of RXD plus RXC). Illegal
// blocks and illegal sequences are replaced by eight /E/ characters, and each
// replacement is counted in a saturating error counter.
//
// Parameters
//   ERR_CNT_WIDTH   width of the saturating decode-error counter
//
// Ports
//   clk             PCS clock; all logic runs on the rising edge
//   rst             synchronous, active-high reset
//   rx_block        [65:64] sync header, [63:56] block type for control blocks
//   rx_block_valid  rx_block carries a new block this cycle
//   block_lock      block-sync lock indication from the block-sync stage
//   xgmii_rxd       decoded lanes, lane k = [8k+7:8k], lane 0 first on the wire
//   xgmii_rxc       bit k set = lane k holds a control character
//   xgmii_rx_valid  xgmii_rxd/xgmii_rxc were updated this cycle
//   decode_error    the word output this cycle was forced to /E/
//   err_count       saturating count of decode_error pulses
// ---------------------------------------------------------------------------
module pcs_10g_dec_64b66b #(
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [65:0]              rx_block,
   input  logic                     rx_block_valid,
   input  logic                     block_lock,
   output logic [63:0]              xgmii_rxd,
   output logic [7:0]               xgmii_rxc,
   output logic                     xgmii_rx_valid,
   output logic                     decode_error,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam logic [1:0]  SYNC_DATA = 2'b01;
   localparam logic [1:0]  SYNC_CTRL = 2'b10;

   localparam logic [7:0]  TYPE_IDLE = 8'h1E;
   localparam logic [7:0]  TYPE_S0   = 8'h78;
   localparam logic [7:0]  TYPE_S4   = 8'h33;

   localparam logic [7:0]  CHAR_IDLE  = 8'h07;
   localparam logic [7:0]  CHAR_START = 8'hFB;
   localparam logic [7:0]  CHAR_TERM  = 8'hFD;
   localparam logic [7:0]  CHAR_ERROR = 8'hFE;

   localparam logic [63:0] IDLE_RXD   = 64'h0707070707070707;
   localparam logic [63:0] ERROR_RXD  = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] LF_RXD     = 64'h0100009C0100009C;
   localparam logic [7:0]  LF_RXC     = 8'h11;

   typedef enum logic [2:0] {
      RX_INIT,
      RX_C,
      RX_D,
      RX_T,
      RX_E
   } rxState_e;

   typedef enum logic [2:0] {
      BLK_C,
      BLK_S,
      BLK_D,
      BLK_T,
      BLK_E
   } blkClass_e;

   rxState_e                 state_q, state_d;
   logic [63:0]              rxd_q, rxd_d;
   logic [7:0]               rxc_q, rxc_d;
   logic                     rxValid_q, rxValid_d;
   logic                     decErr_q, decErr_d;
   logic [ERR_CNT_WIDTH-1:0] errCnt_q, errCnt_d;

   blkClass_e   blkClass;
   logic [63:0] blkRxd;
   logic [7:0]  blkRxc;
   logic [63:0] ctrlRxd;
   logic        ctrlOk;
   logic [63:0] termRxd;
   logic [7:0]  termRxc;
   logic [2:0]  termLane;
   logic        isTerm;

   // Pre-decode all-control blocks. There are eight 7-bit control codes that
   // sit back to back in the low 56 bits. Only idle (00) and error (1E) are
   // accepted here. Any other code marks the whole block as an error block.
   always_comb begin
      ctrlRxd = IDLE_RXD;
      ctrlOk  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         case (rx_block[7*k +: 7])
            7'h00: ctrlRxd[8*k +: 8] = CHAR_IDLE;
            7'h1E: ctrlRxd[8*k +: 8] = CHAR_ERROR;
            default: begin
               ctrlRxd[8*k +: 8] = CHAR_ERROR;
               ctrlOk            = 1'b0;
            end
         endcase
      end
   end

   // Terminate blocks. The block type gives the lane n that holds /T/. Lanes
   // below n carry data bytes taken from the bottom of the payload. Lanes
   // above n are idles. RXC is set from lane n upward.
   always_comb begin
      isTerm   = 1'b1;
      termLane = 3'd0;
      case (rx_block[63:56])
         8'h87:   termLane = 3'd0;
         8'h99:   termLane = 3'd1;
         8'hAA:   termLane = 3'd2;
         8'hB4:   termLane = 3'd3;
         8'hCC:   termLane = 3'd4;
         8'hD2:   termLane = 3'd5;
         8'hE1:   termLane = 3'd6;
         8'hFF:   termLane = 3'd7;
         default: isTerm   = 1'b0;
      endcase
      termRxd = IDLE_RXD;
      termRxc = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         if (3'(k) < termLane) begin
            termRxd[8*k +: 8] = rx_block[8*k +: 8];
            termRxc[k]        = 1'b0;
         end else if (3'(k) == termLane) begin
            termRxd[8*k +: 8] = CHAR_TERM;
         end
      end
   end

   // Classify the incoming block and produce the XGMII word it would decode
   // to. The FSM decides later whether that word is used or replaced by /E/.
   always_comb begin
      blkClass = BLK_E;
      blkRxd   = ERROR_RXD;
      blkRxc   = 8'hFF;
      if (rx_block[65:64] == SYNC_DATA) begin
         blkClass = BLK_D;
         blkRxd   = rx_block[63:0];
         blkRxc   = 8'h00;
      end else if (rx_block[65:64] == SYNC_CTRL) begin
         case (rx_block[63:56])
            TYPE_IDLE: begin
               if (ctrlOk) begin
                  blkClass = BLK_C;
                  blkRxd   = ctrlRxd;
                  blkRxc   = 8'hFF;
               end
            end
            TYPE_S0: begin
               blkClass = BLK_S;
               blkRxd   = {rx_block[55:0], CHAR_START};
               blkRxc   = 8'h01;
            end
            TYPE_S4: begin
               blkClass = BLK_S;
               blkRxd   = {rx_block[55:32], CHAR_START, {4{CHAR_IDLE}}};
               blkRxc   = 8'h1F;
            end
            default: begin
               if (isTerm) begin
                  blkClass = BLK_T;
                  blkRxd   = termRxd;
                  blkRxc   = termRxc;
               end
            end
         endcase
      end
   end

   // Receive sequence FSM, next state and next outputs. Loss of block lock
   // wins over everything else. It sends the FSM back to RX_INIT and outputs
   // Local Fault. With lock held, the FSM only moves on valid blocks. Any
   // transition into RX_E, including RX_E to RX_E, puts /E/ on the output and
   // counts an error.
   always_comb begin
      state_d   = state_q;
      rxd_d     = rxd_q;
      rxc_d     = rxc_q;
      rxValid_d = 1'b0;
      decErr_d  = 1'b0;
      errCnt_d  = errCnt_q;
      if (!block_lock) begin
         state_d   = RX_INIT;
         rxd_d     = LF_RXD;
         rxc_d     = LF_RXC;
         rxValid_d = 1'b1;
      end else if (rx_block_valid) begin
         rxValid_d = 1'b1;
         case (state_q)
            RX_INIT, RX_C, RX_T: begin
               case (blkClass)
                  BLK_C:   state_d = RX_C;
                  BLK_S:   state_d = RX_D;
                  default: state_d = RX_E;
               endcase
            end
            RX_D: begin
               case (blkClass)
                  BLK_D:   state_d = RX_D;
                  BLK_T:   state_d = RX_T;
                  default: state_d = RX_E;
               endcase
            end
            RX_E: begin
               case (blkClass)
                  BLK_C:   state_d = RX_C;
                  BLK_S:   state_d = RX_D;
                  BLK_D:   state_d = RX_D;
                  BLK_T:   state_d = RX_T;
                  default: state_d = RX_E;
               endcase
            end
            default: state_d = RX_E;
         endcase
         if (state_d == RX_E) begin
            rxd_d    = ERROR_RXD;
            rxc_d    = 8'hFF;
            decErr_d = 1'b1;
            if (errCnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
               errCnt_d = errCnt_q + 1'b1;
            end
         end else begin
            rxd_d = blkRxd;
            rxc_d = blkRxc;
         end
      end
   end

   // State and output registers. Reset puts idles on XGMII with valid low,
   // clears the error counter and sends the FSM back to RX_INIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RX_INIT;
         rxd_q     <= IDLE_RXD;
         rxc_q     <= 8'hFF;
         rxValid_q <= 1'b0;
         decErr_q  <= 1'b0;
         errCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         rxd_q     <= rxd_d;
         rxc_q     <= rxc_d;
         rxValid_q <= rxValid_d;
         decErr_q  <= decErr_d;
         errCnt_q  <= errCnt_d;
      end
   end

   assign xgmii_rxd      = rxd_q;
   assign xgmii_rxc      = rxc_q;
   assign xgmii_rx_valid = rxValid_q;
   assign decode_error   = decErr_q;
   assign err_count      = errCnt_q;

endmodule

// File: tb/tb_pcs_10g_dec_64b66b.sv
// ---------------------------------------------------------------------------
// tb_pcs_10g_dec_64b66b
//
// Testbench for the 64B/66B receive decoder. It runs in this order:
//   - a table of directed vectors with hand-derived expected outputs
//   - randomized blocks checked against a behavioural lane-level model
//   - counter saturation on a second instance built with a 4-bit counter
//   - lock loss in the middle of a frame, and reset in the middle of a frame
// ---------------------------------------------------------------------------
module tb_pcs_10g_dec_64b66b;

   logic        clk = 1'b0;
   logic        rst;
   logic [65:0] rxBlock;
   logic        rxBlockValid;
   logic        blockLock;

   logic [63:0] rxd,  rxd4;
   logic [7:0]  rxc,  rxc4;
   logic        rxValid, rxValid4;
   logic        decErr,  decErr4;
   logic [15:0] errCnt;
   logic [3:0]  errCnt4;

   int vecCount  = 0;
   int missCount = 0;

   // Behavioural model state. The receive state is one letter: I, C, D, T, E.
   byte         mState;
   logic [63:0] mRxd;
   logic [7:0]  mRxc;
   logic        mValid;
   logic        mErr;
   int          mCnt;

   logic [7:0] termTypes [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

   typedef struct {
      logic [65:0] blk;
      logic        valid;
      logic        lock;
      logic        rstIn;
      logic [63:0] expRxd;
      logic [7:0]  expRxc;
      logic        expValid;
      logic        expErr;
      logic [15:0] expCnt;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   pcs_10g_dec_64b66b #(.ERR_CNT_WIDTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_block       (rxBlock),
      .rx_block_valid (rxBlockValid),
      .block_lock     (blockLock),
      .xgmii_rxd      (rxd),
      .xgmii_rxc      (rxc),
      .xgmii_rx_valid (rxValid),
      .decode_error   (decErr),
      .err_count      (errCnt)
   );

   pcs_10g_dec_64b66b #(.ERR_CNT_WIDTH(4)) dut4 (
      .clk            (clk),
      .rst            (rst),
      .rx_block       (rxBlock),
      .rx_block_valid (rxBlockValid),
      .block_lock     (blockLock),
      .xgmii_rxd      (rxd4),
      .xgmii_rxc      (rxc4),
      .xgmii_rx_valid (rxValid4),
      .decode_error   (decErr4),
      .err_count      (errCnt4)
   );

   function automatic vec_t mkVec(input logic [65:0] blk, input logic valid, input logic lock,
                                  input logic rstIn, input logic [63:0] eRxd, input logic [7:0] eRxc,
                                  input logic eV, input logic eE, input logic [15:0] eC);
      vec_t v;
      v.blk = blk; v.valid = valid; v.lock = lock; v.rstIn = rstIn;
      v.expRxd = eRxd; v.expRxc = eRxc; v.expValid = eV; v.expErr = eE; v.expCnt = eC;
      return v;
   endfunction

   // Drive one cycle of inputs and sample the outputs 1 time unit after the edge.
   task automatic applyStimulus(input logic [65:0] blk, input logic valid, input logic lock,
                                input logic rstIn);
      rxBlock      = blk;
      rxBlockValid = valid;
      blockLock    = lock;
      rst          = rstIn;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] eRxd, input logic [7:0] eRxc,
                              input logic eV, input logic eE, input logic [15:0] eC);
      vecCount++;
      if (rxd !== eRxd) begin
         missCount++;
         $display("[TB] FAIL %s rxd got %h want %h", tag, rxd, eRxd);
      end
      if (rxc !== eRxc) begin
         missCount++;
         $display("[TB] FAIL %s rxc got %h want %h", tag, rxc, eRxc);
      end
      if (rxValid !== eV) begin
         missCount++;
         $display("[TB] FAIL %s rx_valid got %b want %b", tag, rxValid, eV);
      end
      if (decErr !== eE) begin
         missCount++;
         $display("[TB] FAIL %s decode_error got %b want %b", tag, decErr, eE);
      end
      if (errCnt !== eC) begin
         missCount++;
         $display("[TB] FAIL %s err_count got %0d want %0d", tag, errCnt, eC);
      end
   endtask

   // Sort a block into C/S/D/T/E following the block-format rules.
   function automatic byte classify(input logic [65:0] b, output int termN);
      logic [7:0] ty;
      termN = -1;
      if (b[65:64] == 2'b01) return "D";
      if (b[65:64] != 2'b10) return "E";
      ty = b[63:56];
      if (ty == 8'h1E) begin
         for (int k = 0; k < 8; k++) begin
            if (b[7*k +: 7] != 7'h00 && b[7*k +: 7] != 7'h1E) return "E";
         end
         return "C";
      end
      if (ty == 8'h78 || ty == 8'h33) return "S";
      for (int n = 0; n < 8; n++) begin
         if (ty == termTypes[n]) begin
            termN = n;
            return "T";
         end
      end
      return "E";
   endfunction

   // Model of one clock of the decoder, worked out lane by lane.
   task automatic modelStep(input logic [65:0] b, input logic valid, input logic lock,
                            input logic rstIn);
      byte        kind;
      int         n;
      bit         legal;
      logic [7:0] lane [8];
      logic       ctl  [8];
      if (rstIn) begin
         mState = "I"; mRxd = 64'h0707070707070707; mRxc = 8'hFF;
         mValid = 1'b0; mErr = 1'b0; mCnt = 0;
      end else if (!lock) begin
         mState = "I"; mRxd = 64'h0100009C0100009C; mRxc = 8'h11;
         mValid = 1'b1; mErr = 1'b0;
      end else if (!valid) begin
         mValid = 1'b0; mErr = 1'b0;
      end else begin
         mValid = 1'b1;
         kind   = classify(b, n);
         if (kind == "E")        legal = 1'b0;
         else if (mState == "E") legal = 1'b1;
         else if (mState == "D") legal = (kind == "D" || kind == "T");
         else                    legal = (kind == "C" || kind == "S");
         if (!legal) begin
            mState = "E"; mRxd = {8{8'hFE}}; mRxc = 8'hFF; mErr = 1'b1;
            if (mCnt < 65535) mCnt++;
         end else begin
            mErr = 1'b0;
            for (int k = 0; k < 8; k++) begin
               lane[k] = 8'h07; ctl[k] = 1'b1;
            end
            if (kind == "D") begin
               for (int k = 0; k < 8; k++) begin
                  lane[k] = b[8*k +: 8]; ctl[k] = 1'b0;
               end
            end else if (kind == "C") begin
               for (int k = 0; k < 8; k++)
                  lane[k] = (b[7*k +: 7] == 7'h00) ? 8'h07 : 8'hFE;
            end else if (kind == "S" && b[63:56] == 8'h78) begin
               lane[0] = 8'hFB;
               for (int k = 1; k < 8; k++) begin
                  lane[k] = b[8*(k-1) +: 8]; ctl[k] = 1'b0;
               end
            end else if (kind == "S") begin
               lane[4] = 8'hFB;
               for (int k = 5; k < 8; k++) begin
                  lane[k] = b[32 + 8*(k-5) +: 8]; ctl[k] = 1'b0;
               end
            end else begin
               for (int k = 0; k < n; k++) begin
                  lane[k] = b[8*k +: 8]; ctl[k] = 1'b0;
               end
               lane[n] = 8'hFD;
            end
            for (int k = 0; k < 8; k++) begin
               mRxd[8*k +: 8] = lane[k];
               mRxc[k]        = ctl[k];
            end
            mState = (kind == "S") ? "D" : kind;
         end
      end
   endtask

   task automatic stepAndCheck(input string tag, input logic [65:0] b, input logic valid,
                               input logic lock, input logic rstIn);
      modelStep(b, valid, lock, rstIn);
      applyStimulus(b, valid, lock, rstIn);
      checkOutput(tag, mRxd, mRxc, mValid, mErr, 16'(mCnt));
   endtask

   // Random block. When the model is inside a frame, data and terminate
   // blocks are favoured so that long legal frames also show up.
   function automatic logic [65:0] randBlock();
      int          r;
      logic [63:0] d;
      logic [55:0] codes;
      int          c;
      r = $urandom_range(0, 99);
      d = {$urandom, $urandom};
      if (mState == "D" && $urandom_range(0, 99) < 70)
         r = ($urandom_range(0, 3) == 0) ? 80 : 60;
      if (r < 25) begin
         codes = '0;
         for (int k = 0; k < 8; k++) begin
            c = $urandom_range(0, 99);
            if (c < 85)      codes[7*k +: 7] = 7'h00;
            else if (c < 95) codes[7*k +: 7] = 7'h1E;
            else             codes[7*k +: 7] = 7'($urandom_range(1, 127));
         end
         return {2'b10, 8'h1E, codes};
      end
      if (r < 40) return {2'b10, 8'h78, d[55:0]};
      if (r < 48) return {2'b10, 8'h33, d[55:0]};
      if (r < 75) return {2'b01, d};
      if (r < 90) return {2'b10, termTypes[$urandom_range(0, 7)], d[55:0]};
      if (r < 95) return {($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, d};
      return {2'b10, 8'($urandom_range(0, 255)), d[55:0]};
   endfunction

   initial begin
      logic [65:0] b;
      logic        v, l, rs;
      int          exp4;

      rst = 1'b1; rxBlock = '0; rxBlockValid = 1'b0; blockLock = 1'b1;

      // Directed table, expected values worked out by hand from the block rules.
      vecs.push_back(mkVec(66'h0, 0, 1, 1, 64'h0707070707070707, 8'hFF, 0, 0, 0));
      vecs.push_back(mkVec({2'b10, 8'h1E, 56'h0}, 1, 1, 0, 64'h0707070707070707, 8'hFF, 1, 0, 0));
      vecs.push_back(mkVec({2'b10, 8'h78, 56'hD5555555555555}, 1, 1, 0, 64'hD5555555555555FB, 8'h01, 1, 0, 0));
      vecs.push_back(mkVec({2'b01, 64'h0102030405060708}, 1, 1, 0, 64'h0102030405060708, 8'h00, 1, 0, 0));
      vecs.push_back(mkVec({2'b10, 8'hFF, 56'h11223344556677}, 1, 1, 0, 64'hFD11223344556677, 8'h80, 1, 0, 0));
      vecs.push_back(mkVec({2'b10, 8'h1E, 56'h0}, 1, 1, 0, 64'h0707070707070707, 8'hFF, 1, 0, 0));
      vecs.push_back(mkVec({2'b00, 64'h0123456789ABCDEF}, 1, 1, 0, 64'hFEFEFEFEFEFEFEFE, 8'hFF, 1, 1, 1));
      vecs.push_back(mkVec({2'b10, 8'h1E, 56'h0}, 1, 1, 0, 64'h0707070707070707, 8'hFF, 1, 0, 1));
      vecs.push_back(mkVec({2'b01, 64'hAABBCCDDEEFF0011}, 1, 1, 0, 64'hFEFEFEFEFEFEFEFE, 8'hFF, 1, 1, 2));
      vecs.push_back(mkVec({2'b10, 8'h33, 56'hABCDEF00000000}, 1, 1, 0, 64'hABCDEFFB07070707, 8'h1F, 1, 0, 2));
      vecs.push_back(mkVec({2'b10, 8'hB4, 56'h00000000A1A2A3}, 1, 1, 0, 64'h07070707FDA1A2A3, 8'hF8, 1, 0, 2));
      vecs.push_back(mkVec({2'b01, 64'h5A5A5A5A5A5A5A5A}, 0, 1, 0, 64'h07070707FDA1A2A3, 8'hF8, 0, 0, 2));
      vecs.push_back(mkVec({2'b10, 8'h1E, 56'h1E}, 1, 1, 0, 64'h07070707070707FE, 8'hFF, 1, 0, 2));
      vecs.push_back(mkVec({2'b10, 8'h1E, 56'(56'h2D << 35)}, 1, 1, 0, 64'hFEFEFEFEFEFEFEFE, 8'hFF, 1, 1, 3));
      vecs.push_back(mkVec({2'b01, 64'h0}, 0, 0, 0, 64'h0100009C0100009C, 8'h11, 1, 0, 3));
      vecs.push_back(mkVec({2'b01, 64'h1111111111111111}, 1, 1, 0, 64'hFEFEFEFEFEFEFEFE, 8'hFF, 1, 1, 4));
      vecs.push_back(mkVec({2'b10, 8'h78, 56'h66554433221100}, 1, 1, 0, 64'h66554433221100FB, 8'h01, 1, 0, 4));
      vecs.push_back(mkVec({2'b10, 8'h55, 56'h0}, 1, 1, 0, 64'hFEFEFEFEFEFEFEFE, 8'hFF, 1, 1, 5));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].blk, vecs[i].valid, vecs[i].lock, vecs[i].rstIn);
         checkOutput($sformatf("table%0d", i), vecs[i].expRxd, vecs[i].expRxc,
                     vecs[i].expValid, vecs[i].expErr, vecs[i].expCnt);
      end

      // Randomized phase against the behavioural model.
      stepAndCheck("rand_rst", 66'h0, 0, 1, 1);
      for (int i = 0; i < 600; i++) begin
         b  = randBlock();
         v  = ($urandom_range(0, 99) < 85);
         l  = ($urandom_range(0, 99) >= 2);
         rs = ($urandom_range(0, 199) == 0);
         stepAndCheck($sformatf("rand%0d", i), b, v, l, rs);
      end

      // Counter saturation: the 4-bit instance must stop at 15 and the 16-bit one keeps going.
      stepAndCheck("sat_rst", 66'h0, 0, 1, 1);
      for (int i = 1; i <= 20; i++) begin
         stepAndCheck($sformatf("sat_main%0d", i), {2'b11, 64'hDEADBEEF00C0FFEE}, 1, 1, 0);
         exp4 = (i > 15) ? 15 : i;
         vecCount++;
         if (errCnt4 !== 4'(exp4)) begin
            missCount++;
            $display("[TB] FAIL sat4_%0d err_count got %0d want %0d", i, errCnt4, exp4);
         end
      end

      // Lock lost for three cycles in the middle of a frame, then a data block after relock.
      stepAndCheck("lock_idle", {2'b10, 8'h1E, 56'h0}, 1, 1, 0);
      stepAndCheck("lock_s",    {2'b10, 8'h78, 56'hD5555555555555}, 1, 1, 0);
      stepAndCheck("lock_d",    {2'b01, 64'h1122334455667788}, 1, 1, 0);
      for (int i = 0; i < 3; i++)
         stepAndCheck($sformatf("lock_lf%0d", i), {2'b01, 64'h99AABBCCDDEEFF00}, 1, 0, 0);
      vecCount++;
      if (rxc !== 8'h11 || rxd !== 64'h0100009C0100009C) begin
         missCount++;
         $display("[TB] FAIL lock_lf_const rxd/rxc got %h/%h want 0100009c0100009c/11", rxd, rxc);
      end
      stepAndCheck("lock_relock_d", {2'b01, 64'h0F0E0D0C0B0A0908}, 1, 1, 0);
      stepAndCheck("lock_s2",       {2'b10, 8'h78, 56'h01020304050607}, 1, 1, 0);

      // Reset in the middle of a frame, then a frame that starts cleanly.
      stepAndCheck("mid_d",     {2'b01, 64'h123456789ABCDEF0}, 1, 1, 0);
      stepAndCheck("mid_rst",   {2'b01, 64'h123456789ABCDEF0}, 1, 1, 1);
      checkOutput("mid_rst_const", 64'h0707070707070707, 8'hFF, 1'b0, 1'b0, 16'd0);
      stepAndCheck("post_rst_d",  {2'b01, 64'hCAFEBABE12345678}, 1, 1, 0);
      stepAndCheck("post_rst_c",  {2'b10, 8'h1E, 56'h0}, 1, 1, 0);
      stepAndCheck("post_rst_s",  {2'b10, 8'h33, 56'h77665500000000}, 1, 1, 0);
      stepAndCheck("post_rst_t0", {2'b10, 8'h87, 56'h0}, 1, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
